// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions: memory-unit FSM states and access encodings.
package lc3b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/lc3b_mem_unit_if.sv
// 8-bit request/acknowledge RAM port between the memory unit (master) and RAM (slave).
interface lc3b_mem_unit_if;
  logic [15:0] ram_addr;
  logic        ram_req;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ack;

  modport master (
    output ram_addr, ram_req, ram_we, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_addr, ram_req, ram_we, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/lc3b_mdr_ext.sv
// Assembles loaded bytes into the 16-bit MDR value with zero/sign extension.
module lc3b_mdr_ext
  import lc3b_pkg::*;
(
  input  logic [7:0]  lo_i,
  input  logic [7:0]  hi_i,
  input  logic        size_i,
  input  logic        sext_i,
  output logic [15:0] data_o
);
  always_comb begin
    data_o = '0;
    if (size_i == SIZE_WORD) data_o = {hi_i, lo_i};
    else if (sext_i)         data_o = {{8{lo_i[7]}}, lo_i};
    else                     data_o = {8'h00, lo_i};
  end
endmodule

// File: rtl/lc3b_mem_unit.sv
// LC-3b memory access unit: MAR/MDR plus byte/word transactions over an 8-bit RAM port.
module lc3b_mem_unit
  import lc3b_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mar_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mem_r_w,
  input  logic        mem_size,
  input  logic        mdr_sext,
  input  logic [15:0] wr_data,
  output logic [15:0] mdr_out,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        align_err,
  output logic        bus_err,
  lc3b_mem_unit_if.master ram
);
  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  mem_state_t  state_q, state_d;
  logic [15:0] mar_q, mar_d, mdr_q, mdr_d, wdat_q, wdat_d, addr_q, addr_d;
  logic        rw_q, rw_d, size_q, size_d, sext_q, sext_d;
  logic [7:0]  lo_q, lo_d, wd_q, wd_d;
  logic        req_q, req_d, we_q, we_d, align_q, align_d, berr_q, berr_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [15:0] addr_eff, ext_data;

  lc3b_mdr_ext u_ext (
    .lo_i   ((state_q == LO) ? ram.ram_rdata : lo_q),
    .hi_i   (ram.ram_rdata),
    .size_i (size_q),
    .sext_i (sext_q),
    .data_o (ext_data)
  );

  // Simultaneous ld_mar/ld_mdr: the access must see the address being loaded.
  assign addr_eff = ld_mar ? mar_in : mar_q;

  always_comb begin
    state_d = state_q; mar_d = mar_q; mdr_d = mdr_q; wdat_d = wdat_q;
    rw_d = rw_q; size_d = size_q; sext_d = sext_q; lo_d = lo_q;
    req_d = req_q; addr_d = addr_q; we_d = we_q; wd_d = wd_q;
    wait_d = wait_q; align_d = 1'b0; berr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = mar_in;
        if (ld_mdr) begin
          rw_d = mem_r_w; size_d = mem_size; sext_d = mdr_sext; wdat_d = wr_data;
          if (mem_size == SIZE_WORD && addr_eff[0]) begin
            align_d = 1'b1;
          end else begin
            state_d = LO;
            req_d   = 1'b1;
            addr_d  = addr_eff;
            we_d    = (mem_r_w == MEM_WRITE);
            wd_d    = wr_data[7:0];
            wait_d  = '0;
          end
        end
      end
      LO, HI: begin
        if (ram.ram_ack) begin
          wait_d = '0;
          if (state_q == LO && size_q == SIZE_WORD) begin
            state_d = HI;
            lo_d    = ram.ram_rdata;
            addr_d  = mar_q + 16'd1;
            wd_d    = wdat_q[15:8];
          end else begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            mdr_d   = (rw_q == MEM_READ) ? ext_data : wdat_q;
          end
        end else if (wait_q == CW'(WAIT_MAX - 1)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE; mar_q <= '0; mdr_q <= '0; wdat_q <= '0;
      rw_q <= 1'b0; size_q <= 1'b0; sext_q <= 1'b0; lo_q <= '0;
      req_q <= 1'b0; addr_q <= '0; we_q <= 1'b0; wd_q <= '0;
      wait_q <= '0; align_q <= 1'b0; berr_q <= 1'b0;
    end else begin
      state_q <= state_d; mar_q <= mar_d; mdr_q <= mdr_d; wdat_q <= wdat_d;
      rw_q <= rw_d; size_q <= size_d; sext_q <= sext_d; lo_q <= lo_d;
      req_q <= req_d; addr_q <= addr_d; we_q <= we_d; wd_q <= wd_d;
      wait_q <= wait_d; align_q <= align_d; berr_q <= berr_d;
    end
  end

  assign mdr_out       = mdr_q;
  assign mem_busy      = (state_q != IDLE);
  assign mem_done      = (state_q == DONE);
  assign align_err     = align_q;
  assign bus_err       = berr_q;
  assign ram.ram_req   = req_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_we    = we_q;
  assign ram.ram_wdata = wd_q;
endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Directed bench for lc3b_mem_unit with a wait-state-programmable byte RAM model.
module tb_lc3b_mem_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mar_in, wr_data, mdr_out;
  logic        ld_mar, ld_mdr, mem_r_w, mem_size, mdr_sext;
  logic        mem_busy, mem_done, align_err, bus_err;

  int tests = 0;
  int fails = 0;
  int ack_en = 1;
  int wait_cfg = 0;
  int beat_cnt = 0;
  int seen;
  logic [7:0] mem [0:65535];

  lc3b_mem_unit_if ram_bus ();

  lc3b_mem_unit #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .mar_in(mar_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mem_r_w(mem_r_w), .mem_size(mem_size), .mdr_sext(mdr_sext), .wr_data(wr_data),
    .mdr_out(mdr_out), .mem_busy(mem_busy), .mem_done(mem_done),
    .align_err(align_err), .bus_err(bus_err), .ram(ram_bus)
  );

  always #5 clk = ~clk;

  assign ram_bus.ram_ack   = ram_bus.ram_req && (ack_en != 0) && (beat_cnt >= wait_cfg);
  assign ram_bus.ram_rdata = mem[ram_bus.ram_addr];

  always @(posedge clk) begin
    if (!ram_bus.ram_req || ram_bus.ram_ack) beat_cnt <= 0;
    else beat_cnt <= beat_cnt + 1;
    if (ram_bus.ram_req && ram_bus.ram_ack && ram_bus.ram_we)
      mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic lmar, input logic [15:0] a, input logic rw,
                       input logic sz, input logic sx, input logic [15:0] wd);
    ld_mar = lmar; mar_in = a; ld_mdr = 1'b1;
    mem_r_w = rw; mem_size = sz; mdr_sext = sx; wr_data = wd;
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mar_in = '0; wr_data = '0;
    ld_mar = 1'b0; ld_mdr = 1'b0; mem_r_w = 1'b0; mem_size = 1'b0; mdr_sext = 1'b0;
    mem[16'h3000] = 8'h34; mem[16'h3001] = 8'h12; mem[16'h2001] = 8'h85;
    mem[16'h4000] = 8'h00; mem[16'h4001] = 8'h00;
    tick(); tick();
    check("rst_mdr", 32'(mdr_out), 32'h0);
    check("rst_busy", 32'(mem_busy), 32'h0);
    check("rst_req", 32'(ram_bus.ram_req), 32'h0);
    check("rst_done", 32'(mem_done), 32'h0);
    reset = 1'b1;
    tick();

    // Word read, MAR and access loaded together
    start(1'b1, 16'h3000, 1'b1, 1'b1, 1'b0, 16'h0);
    check("wr1_req", 32'(ram_bus.ram_req), 32'h1);
    check("wr1_addr_lo", 32'(ram_bus.ram_addr), 32'h3000);
    check("wr1_we", 32'(ram_bus.ram_we), 32'h0);
    check("wr1_busy", 32'(mem_busy), 32'h1);
    tick();
    check("wr1_addr_hi", 32'(ram_bus.ram_addr), 32'h3001);
    check("wr1_req_hi", 32'(ram_bus.ram_req), 32'h1);
    tick();
    check("wr1_done", 32'(mem_done), 32'h1);
    check("wr1_mdr", 32'(mdr_out), 32'h1234);
    check("wr1_req_done", 32'(ram_bus.ram_req), 32'h0);

    // Byte reads, sign then zero extended; second accepted right after DONE
    tick();
    check("wr1_idle", 32'(mem_busy), 32'h0);
    ld_mar = 1'b1; mar_in = 16'h2001; tick(); ld_mar = 1'b0;
    start(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0);
    check("bs_addr", 32'(ram_bus.ram_addr), 32'h2001);
    tick();
    check("bs_done", 32'(mem_done), 32'h1);
    check("bs_mdr", 32'(mdr_out), 32'hFF85);
    tick();
    start(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    check("bz_done", 32'(mem_done), 32'h1);
    check("bz_mdr", 32'(mdr_out), 32'h0085);
    tick();

    // Word write with 2 wait states per beat
    wait_cfg = 2;
    start(1'b1, 16'h4000, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    check("ww_addr_lo", 32'(ram_bus.ram_addr), 32'h4000);
    check("ww_we", 32'(ram_bus.ram_we), 32'h1);
    check("ww_wdata_lo", 32'(ram_bus.ram_wdata), 32'hEF);
    tick(); tick(); tick();
    check("ww_addr_hi", 32'(ram_bus.ram_addr), 32'h4001);
    check("ww_wdata_hi", 32'(ram_bus.ram_wdata), 32'hBE);
    check("ww_req_hi", 32'(ram_bus.ram_req), 32'h1);
    tick(); tick();
    check("ww_not_done6", 32'(mem_done), 32'h0);
    tick();
    check("ww_done7", 32'(mem_done), 32'h1);
    check("ww_mdr", 32'(mdr_out), 32'hBEEF);
    check("ww_mem_lo", 32'(mem[16'h4000]), 32'hEF);
    check("ww_mem_hi", 32'(mem[16'h4001]), 32'hBE);
    tick();
    wait_cfg = 0;

    // Misaligned word
    start(1'b1, 16'h4001, 1'b1, 1'b1, 1'b0, 16'h0);
    check("al_err", 32'(align_err), 32'h1);
    check("al_req", 32'(ram_bus.ram_req), 32'h0);
    check("al_busy", 32'(mem_busy), 32'h0);
    tick();
    check("al_pulse", 32'(align_err), 32'h0);
    check("al_mdr", 32'(mdr_out), 32'hBEEF);

    // Ack timeout
    ack_en = 0;
    seen = 0;
    start(1'b1, 16'h3000, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int c = 1; c <= 40; c++) begin
      if (bus_err) begin
        seen = c;
        break;
      end
      tick();
    end
    check("to_cycle", 32'(seen), 32'd16);
    check("to_busy", 32'(mem_busy), 32'h0);
    check("to_req", 32'(ram_bus.ram_req), 32'h0);
    check("to_mdr", 32'(mdr_out), 32'hBEEF);
    tick();
    check("to_once", 32'(bus_err), 32'h0);
    ack_en = 1;
    start(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    tick(); tick();
    check("retry_done", 32'(mem_done), 32'h1);
    check("retry_mdr", 32'(mdr_out), 32'h1234);
    tick();

    // ld_mdr while busy ignored, then reset during HI
    start(1'b1, 16'h3000, 1'b1, 1'b1, 1'b0, 16'h0);
    ld_mar = 1'b1; mar_in = 16'h5000; ld_mdr = 1'b1; mem_size = 1'b0;
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    check("busy_ign_addr", 32'(ram_bus.ram_addr), 32'h3001);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rh_req", 32'(ram_bus.ram_req), 32'h0);
    check("rh_mdr", 32'(mdr_out), 32'h0);
    check("rh_busy", 32'(mem_busy), 32'h0);
    check("rh_done", 32'(mem_done), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
